capture_row_scheduler: RTL and testbench
========================================

// Module: capture_row_scheduler
// PURPOSE
//  Sequences completed capture rows (row_index/row_data/row_ready from the VGA capture
//  block) into a word-wide frame buffer, sharing the single buffer port with a display
//  read requester. Latches each row into a shadow register on row_ready rise and writes
//  it out as ROW_BITS/WORD_W words. Sits between capture front end and frame memory.
// PARAMETERS
//  ROW_BITS  320  bits per captured row
//  WORD_W    16   frame buffer data width; ROW_BITS % WORD_W == 0
//  ROWS      240  rows stored; row_index >= ROWS ignored
//  ADDR_W    13   frame buffer address width; must hold ROWS*ROW_BITS/WORD_W
// PORTS
//  pixel_clk  in   1         single clock, all logic rising-edge
//  rst_n      in   1         asynchronous, active-low reset
//  row_ready  in   1         asynchronous level from capture (high = row complete)
//  row_index  in   8         row number, stable while row_ready high
//  row_data   in   ROW_BITS  row pixels, bit 0 = leftmost, stable while row_ready high
//  rd_req     in   1         display read request, level, held until rd_ack
//  rd_addr    in   ADDR_W    read word address, stable while rd_req high
//  rd_ack     out  1         one-cycle pulse, rd_data valid same cycle
//  rd_data    out  WORD_W    read data
//  mem_we     out  1         buffer write strobe
//  mem_re     out  1         buffer read strobe; mem_rdata valid next cycle
//  mem_addr   out  ADDR_W    buffer address
//  mem_wdata  out  WORD_W    buffer write data
//  mem_rdata  in   WORD_W    buffer read data, 1-cycle latency
//  ovr_clr    in   1         clears overrun
//  busy       out  1         row write in progress
//  overrun    out  1         sticky: row arrived while busy
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state IDLE, word counter 0, shadow 0,
//    last_grant=READ (first contention goes to write). Row in progress abandoned.
//  - row_ready passes 2-flop sync then rising-edge detect (2-3 cycle latency).
//  - On edge: row_index<ROWS and !busy -> latch row_data/row_index, wcnt=0, busy=1
//    next cycle. row_index>=ROWS -> ignored, no flag. busy -> row dropped, overrun=1.
//  - overrun cleared by ovr_clr; set and clear in same cycle -> set wins.
//  - Base = row_index*WPR, WPR=ROW_BITS/WORD_W (20: (idx<<4)+(idx<<2)), ADDR_W wide.
//  - FSM states: IDLE, WRITE, RD_WAIT. WRITE is a grant cycle, not a burst.
//    IDLE/WRITE arbitrate each cycle among write pending (busy) and rd_req:
//    only one -> grant it; both -> grant opposite of last_grant (strict alternate).
//    Write grant: mem_we=1, mem_addr=base+wcnt, mem_wdata=shadow[wcnt*WORD_W +: WORD_W],
//    wcnt++; grant of word WPR-1 clears busy next cycle, wcnt->0.
//    Read grant: mem_re=1, mem_addr=rd_addr, go RD_WAIT.
//    RD_WAIT: rd_ack=1, rd_data=mem_rdata, no new grant this cycle, -> IDLE.
//  - mem_we and mem_re never both 1. Strobes registered, 1 cycle after grant decision.
//  - Row throughput: WPR cycles uncontended, <=3*WPR with continuous reads.
//  - New edge the cycle busy clears: accepted (busy seen as 0).
// STRUCTURE
//  - Package vga_capture_pkg: ROW_BITS, WORD_W, ROWS, ADDR_W, WPR, state enum
//    {IDLE, WRITE, RD_WAIT}, grant enum {GNT_WR, GNT_RD}.
//  - Sub-module sync_edge: 2-flop synchroniser + rising-edge pulse (async rst_n).
//  - Rest (arbiter FSM, shadow reg, address gen) in this module.
// TESTING
//  1 Row idx=3, data=pattern (word k = 16'hA000+k), no reads -> 20 writes, addr 60..79,
//    wdata A000..A013 in order, busy high exactly 20 cycles.
//  2 rd_req held, rd_addr=100, mem model returns 16'hBEEF -> mem_re 1 cycle,
//    rd_ack+rd_data=BEEF next cycle, no second mem_re while rd_req held until ack.
//  3 Row write + continuous rd_req -> grants alternate W,R(+wait); all 20 words written,
//    every read acked; first contended grant is write.
//  4 Second row_ready edge at word 5 -> overrun=1, writes continue for first row only;
//    ovr_clr pulse -> overrun=0; ovr_clr coincident with new overrun -> stays 1.
//  5 row_index=240 -> no writes, busy and overrun stay 0.
//  6 rst_n low at word 10 -> all outputs 0 immediately; next row writes from wcnt=0.

Source files
------------

// File: rtl/vga_capture_pkg.sv
// rtl/vga_capture_pkg.sv - shared constants and types for the capture row scheduler
package vga_capture_pkg;

    localparam int ROW_BITS = 320;
    localparam int WORD_W   = 16;
    localparam int ROWS     = 240;
    localparam int ADDR_W   = 13;
    localparam int WPR      = ROW_BITS / WORD_W;
    localparam int WCNT_W   = $clog2(WPR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] idx);
        return ADDR_W'(idx) * ADDR_W'(WPR);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchroniser with rising-edge pulse
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/capture_row_scheduler.sv
// rtl/capture_row_scheduler.sv - writes latched capture rows to the frame buffer, sharing the port with display reads
module capture_row_scheduler
    import vga_capture_pkg::*;
(
    input  logic                pixel_clk,
    input  logic                rst_n,
    input  logic                row_ready,
    input  logic [7:0]          row_index,
    input  logic [ROW_BITS-1:0] row_data,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ack,
    output logic [WORD_W-1:0]   rd_data,
    output logic                mem_we,
    output logic                mem_re,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                ovr_clr,
    output logic                busy,
    output logic                overrun
);

    logic row_edge;

    sync_edge u_sync_edge (
        .clk_i   (pixel_clk),
        .rst_ni  (rst_n),
        .async_i (row_ready),
        .pulse_o (row_edge)
    );

    state_e              state_q, state_d;
    grant_e              last_grant_q, last_grant_d;
    logic [ROW_BITS-1:0] shadow_q, shadow_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                rd_ack_q, rd_ack_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic row_valid;
    logic can_grant;
    logic rd_pend;
    logic gnt_wr;
    logic gnt_rd;

    assign row_valid = (32'(row_index) < ROWS);
    assign can_grant = (state_q != RD_WAIT);
    // rd_req is still high during its ack cycle; masking it stops a duplicate read
    assign rd_pend   = rd_req & ~rd_ack_q;
    assign gnt_wr    = can_grant & busy_q & (~rd_pend | (last_grant_q == GNT_RD));
    assign gnt_rd    = can_grant & rd_pend & (~busy_q | (last_grant_q == GNT_WR));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        shadow_d     = shadow_q;
        base_d       = base_q;
        wcnt_d       = wcnt_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        rd_ack_d     = 1'b0;

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (row_edge && row_valid) begin
            if (busy_q) begin
                overrun_d = 1'b1;
            end else begin
                shadow_d = row_data;
                base_d   = row_base(row_index);
                wcnt_d   = '0;
                busy_d   = 1'b1;
            end
        end

        case (state_q)
            RD_WAIT: begin
                rd_ack_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                if (gnt_wr) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = base_q + ADDR_W'(wcnt_q);
                    mem_wdata_d  = shadow_q[WORD_W*32'(wcnt_q) +: WORD_W];
                    last_grant_d = GNT_WR;
                    state_d      = WRITE;
                    if (wcnt_q == WCNT_W'(WPR - 1)) begin
                        wcnt_d = '0;
                        busy_d = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end else if (gnt_rd) begin
                    mem_re_d     = 1'b1;
                    mem_addr_d   = rd_addr;
                    last_grant_d = GNT_RD;
                    state_d      = RD_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_RD;
            shadow_q     <= '0;
            base_q       <= '0;
            wcnt_q       <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            shadow_q     <= shadow_d;
            base_q       <= base_d;
            wcnt_q       <= wcnt_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            rd_ack_q     <= rd_ack_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // mem_rdata arrives the cycle after mem_re, which is exactly the ack cycle
    assign rd_data   = rd_ack_q ? mem_rdata : '0;
    assign rd_ack    = rd_ack_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_capture_row_scheduler.sv
// tb/tb_capture_row_scheduler.sv - directed scoreboard bench for capture_row_scheduler
module tb_capture_row_scheduler;

    logic          clk;
    logic          rst_n;
    logic          row_ready;
    logic [7:0]    row_index;
    logic [319:0]  row_data;
    logic          rd_req;
    logic [12:0]   rd_addr;
    logic          rd_ack;
    logic [15:0]   rd_data;
    logic          mem_we;
    logic          mem_re;
    logic [12:0]   mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          ovr_clr;
    logic          busy;
    logic          overrun;

    capture_row_scheduler dut (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .row_ready (row_ready),
        .row_index (row_index),
        .row_data  (row_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ovr_clr   (ovr_clr),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [12:0] exp_rd_addr[$];
    logic [15:0] exp_rd_data[$];
    logic [1:0]  strobe_log[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    int n_re = 0;
    int busy_cycles = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame buffer model: address-derived contents, one location pinned to BEEF
    function automatic logic [15:0] mem_val(input logic [12:0] a);
        return (a == 13'd100) ? 16'hBEEF : (16'h5000 ^ 16'(a));
    endfunction

    initial mem_rdata = 16'h0;
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_val(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (mem_we || mem_re) chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
            if (mem_we) begin
                n_wr++;
                strobe_log.push_back(2'd1);
                chk("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) chk("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
            end
            if (mem_re) begin
                n_re++;
                strobe_log.push_back(2'd2);
                chk("re_pending", 32'(exp_rd_addr.size() != 0), 32'd1);
                if (exp_rd_addr.size() != 0) chk("re_addr", 32'(mem_addr), 32'(exp_rd_addr.pop_front()));
            end
            if (rd_ack) begin
                chk("ack_pending", 32'(exp_rd_data.size() != 0), 32'd1);
                if (exp_rd_data.size() != 0) chk("rd_data", 32'(rd_data), 32'(exp_rd_data.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input int idx, input logic [15:0] seed, input bit expect_wr);
        for (int k = 0; k < 20; k++) begin
            row_data[k*16 +: 16] = seed + 16'(k);
            if (expect_wr) exp_wr.push_back({13'(idx*20 + k), seed + 16'(k)});
        end
        row_index = 8'(idx);
        row_ready = 1'b1;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_nwr(input int target, input string tag);
        int n = 0;
        while (n_wr < target && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(n_wr), 32'(target));
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_busy"},      32'(busy),      32'd0);
        chk({pfx, "_overrun"},   32'(overrun),   32'd0);
        chk({pfx, "_mem_we"},    32'(mem_we),    32'd0);
        chk({pfx, "_mem_re"},    32'(mem_re),    32'd0);
        chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({pfx, "_rd_ack"},    32'(rd_ack),    32'd0);
        chk({pfx, "_rd_data"},   32'(rd_data),   32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        row_ready = 1'b0;
        rd_req    = 1'b0;
        ovr_clr   = 1'b0;
        exp_wr.delete();
        exp_rd_addr.delete();
        exp_rd_data.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int wr0;
        int re0;
        int n;
        int nrd;

        row_index = 8'd0;
        row_data  = '0;
        rd_addr   = 13'd0;
        do_reset();
        chk_outputs_zero("reset");

        // 1: uncontended row write
        busy_cycles = 0;
        wr0 = n_wr;
        start_row(3, 16'hA000, 1'b1);
        wait_busy(1'b1, "t1_busy_rise");
        row_ready = 1'b0;
        wait_busy(1'b0, "t1_busy_fall");
        tick();
        tick();
        chk("t1_writes", 32'(n_wr - wr0), 32'd20);
        chk("t1_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd20);

        // 2: single read, no repeat while rd_req held
        re0 = n_re;
        rd_addr = 13'd100;
        rd_req = 1'b1;
        exp_rd_addr.push_back(13'd100);
        exp_rd_data.push_back(16'hBEEF);
        n = 0;
        while (rd_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t2_ack", 32'(rd_ack), 32'd1);
        chk("t2_latency", 32'(n), 32'd2);
        chk("t2_data_now", 32'(rd_data), 32'hBEEF);
        rd_req = 1'b0;
        tick();
        tick();
        chk("t2_re_once", 32'(n_re - re0), 32'd1);

        // 3: row write against continuous reads
        do_reset();
        strobe_log.delete();
        wr0 = n_wr;
        start_row(7, 16'h7100, 1'b1);
        wait_busy(1'b1, "t3_busy_rise");
        row_ready = 1'b0;
        rd_addr = 13'd4000;
        rd_req = 1'b1;
        exp_rd_addr.push_back(13'd4000);
        exp_rd_data.push_back(mem_val(13'd4000));
        nrd = 1;
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (rd_ack === 1'b1) begin
                if (busy === 1'b0) begin
                    rd_req = 1'b0;
                    break;
                end
                rd_addr = 13'(4000 + nrd);
                exp_rd_addr.push_back(rd_addr);
                exp_rd_data.push_back(mem_val(rd_addr));
                nrd++;
            end
        end
        chk("t3_finished", 32'(rd_req), 32'd0);
        tick();
        tick();
        chk("t3_writes", 32'(n_wr - wr0), 32'd20);
        chk("t3_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("t3_rd_all_acked", 32'(exp_rd_data.size()), 32'd0);
        chk("t3_reads", 32'(nrd), 32'd20);
        chk("t3_log_len", 32'(strobe_log.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] want;
            want = (i % 2 == 0) ? 2'd1 : 2'd2;
            chk("t3_alternate", 32'(strobe_log[i]), 32'(want));
        end

        // 4: overrun set, clear, and set winning over clear
        wr0 = n_wr;
        start_row(10, 16'h1000, 1'b1);
        wait_busy(1'b1, "t4_busy_rise");
        row_ready = 1'b0;
        wait_nwr(wr0 + 5, "t4_word5");
        start_row(11, 16'h2000, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        row_ready = 1'b0;
        chk("t4_overrun_set", 32'(overrun), 32'd1);
        chk("t4_still_busy", 32'(busy), 32'd1);
        wait_busy(1'b0, "t4_busy_fall");
        tick();
        tick();
        chk("t4_first_row_only", 32'(n_wr - wr0), 32'd20);
        chk("t4_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t4_overrun_cleared", 32'(overrun), 32'd0);
        start_row(12, 16'h3000, 1'b1);
        wait_busy(1'b1, "t4b_busy_rise");
        row_ready = 1'b0;
        tick();
        tick();
        start_row(13, 16'h4000, 1'b0);
        tick();
        tick();
        chk("t4_pre_coincide", 32'(overrun), 32'd0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t4_set_wins", 32'(overrun), 32'd1);
        row_ready = 1'b0;
        wait_busy(1'b0, "t4b_busy_fall");
        tick();
        tick();
        chk("t4b_queue_empty", 32'(exp_wr.size()), 32'd0);

        // 5: out-of-range row index is ignored
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        busy_cycles = 0;
        wr0 = n_wr;
        start_row(240, 16'h5500, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        row_ready = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("t5_no_writes", 32'(n_wr - wr0), 32'd0);
        chk("t5_no_busy", 32'(busy_cycles), 32'd0);
        chk("t5_no_overrun", 32'(overrun), 32'd0);

        // 6: reset mid-row, then a fresh row starts from word 0
        wr0 = n_wr;
        start_row(5, 16'h6600, 1'b1);
        wait_busy(1'b1, "t6_busy_rise");
        row_ready = 1'b0;
        wait_nwr(wr0 + 10, "t6_word10");
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_reset");
        exp_wr.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        wr0 = n_wr;
        start_row(6, 16'h6700, 1'b1);
        wait_busy(1'b1, "t6b_busy_rise");
        row_ready = 1'b0;
        wait_busy(1'b0, "t6b_busy_fall");
        tick();
        tick();
        chk("t6_writes", 32'(n_wr - wr0), 32'd20);
        chk("t6_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
